txrx_seq: RTL and testbench
===========================

# txrx_seq

Radio transaction sequencer for the baseband TX/RX path. It takes single-cycle host commands and drives the enables, resets, start pulses and analog power-downs of `tx`, `fsk_demod`, `rx`, `lpf` and `limiter` in the correct order. It handles analog settle time, TX completion and RX CRC/timeout detection, then reports one status code per transaction. It sits between the host register bank and the baseband/analog-control nets, replacing manual testbench-style sequencing.

## Interface
- `TX_GUARD`, 128: cycles after `txstart` during which `txready` is ignored.
- `SETTLE_W`, 8: width of `settle_cycles`.
- `TMO_W`, 16: width of `rx_timeout`.
- `clk` in 1: system clock, 32 MHz.
- `rst` in 1: asynchronous, active-low reset.
- `cmd_tx` in 1: pulse, start a TX transaction.
- `cmd_rx` in 1: pulse, start an RX transaction.
- `abort` in 1: level, cancel the current transaction.
- `settle_cycles` in SETTLE_W: analog/enable settle time.
- `rx_timeout` in TMO_W: RX wait limit in cycles; 0 = no limit.
- `txready` in 1: from `tx`.
- `crc_valid` in 1: from `rx`.
- `tx_en`, `rx_en`, `demod_en` out 1: block enables.
- `txrx_rst` out 1: reset pulse to `tx`/`rx`.
- `txstart`, `rxstart` out 1: single-cycle start pulses.
- `lpf_pd`, `limiter_pd` out 1: analog power-downs, 1 = off.
- `busy` out 1: transaction in progress.
- `done` out 1: single-cycle end-of-transaction pulse.
- `status` out 2: 00 = TX ok, 01 = RX CRC ok, 10 = RX timeout, 11 = aborted. Holds its value until the next `done`.

## Operation
- States: IDLE, TX_SETUP, TX_START, TX_WAIT, RX_SETUP, RX_START, RX_WAIT, FINISH.
- IDLE:
  - `cmd_tx` -> TX_SETUP.
  - `cmd_rx` -> RX_SETUP.
  - Both asserted in the same cycle: TX wins; `cmd_rx` is dropped.
  - Commands outside IDLE are ignored.
- TX_SETUP:
  - `tx_en`=1.
  - `txrx_rst`=1 on the first cycle only.
  - Stay `max(settle_cycles,1)` cycles, then go to TX_START.
- TX_START: `txstart`=1 for one cycle, then TX_WAIT.
- TX_WAIT:
  - Count `TX_GUARD` cycles.
  - After the guard, the first cycle with `txready`=1 -> FINISH with status 00.
- RX_SETUP:
  - `lpf_pd`=`limiter_pd`=0, `rx_en`=`demod_en`=1.
  - `txrx_rst`=1 on the first cycle only.
  - Stay `max(settle_cycles,1)` cycles, then go to RX_START.
- RX_START: `rxstart`=1 for one cycle, then RX_WAIT.
- RX_WAIT:
  - `crc_valid` rising edge -> FINISH with status 01.
  - Timeout counter reaches `rx_timeout` (nonzero) -> FINISH with status 10.
  - Both in the same cycle: CRC wins.
- FINISH:
  - `done`=1 and `status` is updated.
  - All enables drop to 0 and power-downs return to 1 in the same cycle.
  - Next state is IDLE.
- `abort` in any non-IDLE state -> FINISH with status 11 on the next cycle. `abort` in IDLE is ignored.
- `settle_cycles` and `rx_timeout` are sampled on command acceptance; later changes have no effect until the next command.
- `busy` = (state != IDLE).

## Timing
- Reset values:
  - IDLE state.
  - `tx_en`=`rx_en`=`demod_en`=`txrx_rst`=`txstart`=`rxstart`=`busy`=`done`=0.
  - `lpf_pd`=`limiter_pd`=1.
  - `status`=00.
- All outputs are registered.
- Latencies:
  - Command accepted at edge N: `busy` and the enables are high from cycle N+1.
  - `txstart` is asserted at cycle N+1+max(settle,1).
  - `done` asserts exactly one cycle after the terminating condition is sampled.
- `crc_valid` edge detection uses a registered copy of `crc_valid`. That register is cleared on entry to RX_START, so a `crc_valid` left high by a previous packet is not counted.
- Reset asserted mid-transaction: all outputs return to their reset values asynchronously. No `done` is issued.

## Configuration
- `TXRX_SEQ_AUTO_RX_EN` defined:
  - A successful TX goes TX_WAIT -> RX_SETUP directly, with no `done`.
  - `tx_en` drops on that transition.
  - The turnaround uses the same `settle_cycles`.
  - The transaction ends with a single `done` carrying the RX status (01/10/11).
- Not defined: TX and RX are independent transactions; TX ends with status 00.

## Structure
- Shared package `txrx_seq_pkg`: state encoding localparams, status codes (ST_TX_OK, ST_RX_OK, ST_RX_TMO, ST_ABORT), default `TX_GUARD`.
- One sub-module, `txrx_seq_timer`: a loadable down-counter with width parameter, `load`/`value` inputs and a `zero` flag. It is instantiated once and reused for the settle, guard and timeout intervals. Width is max(SETTLE_W, TMO_W, clog2(TX_GUARD+1)).

## Test plan
- TX transaction:
  - Stimulus: `settle_cycles`=4, `cmd_tx` at cycle 10; `txready` low from cycle 16 and high again at cycle 300.
  - Required: `txrx_rst` at cycle 11, `txstart` at cycle 15, `done` with status 00 at cycle 301, `tx_en` low at cycle 301.
- RX success:
  - Stimulus: `cmd_rx`, `rx_timeout`=1000, `crc_valid` pulse 400 cycles after `rxstart`.
  - Required: `lpf_pd`/`limiter_pd` low during the transaction; `done` with status 01 one cycle after the pulse; power-downs back to 1.
- RX timeout: `rx_timeout`=50, no `crc_valid` -> `done` with status 10 exactly 51 cycles after `rxstart`.
- Abort and contention:
  - `abort` in TX_WAIT -> `done` with status 11 next cycle, all enables 0.
  - `cmd_tx` and `cmd_rx` in the same cycle -> TX path only.
- Reset mid-RX_WAIT: drive `rst`=0 asynchronously -> all outputs at reset values immediately, no `done`; a new `cmd_rx` after release works normally.
- With `TXRX_SEQ_AUTO_RX_EN`: loopback of tx -> gf -> fsk_mod_noise -> lpf -> limiter -> fsk_demod -> rx, matching access address -> single `done` with status 01; `txstart` seen once, then `rxstart` once.

Source files
------------

// File: rtl/txrx_seq_pkg.sv
// Shared definitions for the radio transaction sequencer: FSM state encoding,
// per-transaction status codes and the default TX guard interval.
package txrx_seq_pkg;

   localparam int TX_GUARD_DFLT = 128;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      TX_SETUP = 3'd1,
      TX_START = 3'd2,
      TX_WAIT  = 3'd3,
      RX_SETUP = 3'd4,
      RX_START = 3'd5,
      RX_WAIT  = 3'd6,
      FINISH   = 3'd7
   } state_t;

   localparam logic [1:0] ST_TX_OK  = 2'b00;
   localparam logic [1:0] ST_RX_OK  = 2'b01;
   localparam logic [1:0] ST_RX_TMO = 2'b10;
   localparam logic [1:0] ST_ABORT  = 2'b11;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/txrx_seq_timer.sv
// Loadable down-counter shared by the sequencer for settle, TX guard and RX
// timeout intervals; holds at zero and flags it.
module txrx_seq_timer
   import txrx_seq_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         zero
);

   logic [W-1:0] cnt_r;

   // Load wins over counting; the count saturates at zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_r <= {W{1'b0}};
      end else if (load) begin
         cnt_r <= value;
      end else if (cnt_r != {W{1'b0}}) begin
         cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign zero = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/txrx_seq.sv
// Radio TX/RX transaction sequencer. Optional feature macro
// TXRX_SEQ_AUTO_RX_EN chains a successful TX straight into an RX phase.
module txrx_seq
   import txrx_seq_pkg::*;
#(
   parameter int TX_GUARD = TX_GUARD_DFLT,
   parameter int SETTLE_W = 8,
   parameter int TMO_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_tx,
   input  logic                cmd_rx,
   input  logic                abort,
   input  logic [SETTLE_W-1:0] settle_cycles,
   input  logic [TMO_W-1:0]    rx_timeout,
   input  logic                txready,
   input  logic                crc_valid,
   output logic                tx_en,
   output logic                rx_en,
   output logic                demod_en,
   output logic                txrx_rst,
   output logic                txstart,
   output logic                rxstart,
   output logic                lpf_pd,
   output logic                limiter_pd,
   output logic                busy,
   output logic                done,
   output logic [1:0]          status
);

   localparam int TMR_W = max3(SETTLE_W, TMO_W, $clog2(TX_GUARD + 1));
   localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};

   state_t              state_r;
   state_t              state_nx_s;
   logic [1:0]          status_nx_s;
   logic [SETTLE_W-1:0] settle_r;
   logic [TMO_W-1:0]    tmo_r;
   logic                crc_q_r;
   logic                crc_rise_s;
   logic                accept_s;
   logic                rx_on_s;
   logic                ld_s;
   logic [TMR_W-1:0]    ld_val_s;
   logic                tmr_zero_s;

   // Settle phases last max(settle,1) cycles; the timer flags zero on the last one.
   function automatic logic [TMR_W-1:0] settle_ld(input logic [SETTLE_W-1:0] s);
      if (s == {SETTLE_W{1'b0}}) begin
         return TMR_ZERO;
      end else begin
         return TMR_W'(s - SETTLE_W'(1'b1));
      end
   endfunction

   assign crc_rise_s = crc_valid & ~crc_q_r;
   assign accept_s   = (state_r == IDLE) && (cmd_tx || cmd_rx);

   txrx_seq_timer #(.W(TMR_W)) u_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (ld_s),
      .value (ld_val_s),
      .zero  (tmr_zero_s)
   );

   // Next state, status and timer reload decisions.
   always_comb begin
      state_nx_s  = state_r;
      status_nx_s = status;
      ld_s        = 1'b0;
      ld_val_s    = TMR_ZERO;
      if (abort && (state_r != IDLE) && (state_r != FINISH)) begin
         state_nx_s  = FINISH;
         status_nx_s = ST_ABORT;
      end else begin
         case (state_r)
            IDLE: begin
               if (cmd_tx) begin
                  state_nx_s = TX_SETUP;
                  ld_s       = 1'b1;
                  ld_val_s   = settle_ld(settle_cycles);
               end else if (cmd_rx) begin
                  state_nx_s = RX_SETUP;
                  ld_s       = 1'b1;
                  ld_val_s   = settle_ld(settle_cycles);
               end else begin
                  state_nx_s = IDLE;
               end
            end
            TX_SETUP: begin
               if (tmr_zero_s) begin
                  state_nx_s = TX_START;
               end else begin
                  state_nx_s = TX_SETUP;
               end
            end
            TX_START: begin
               state_nx_s = TX_WAIT;
               ld_s       = 1'b1;
               ld_val_s   = TMR_W'(TX_GUARD);
            end
            TX_WAIT: begin
               if (tmr_zero_s && txready) begin
`ifdef TXRX_SEQ_AUTO_RX_EN
                  state_nx_s = RX_SETUP;
                  ld_s       = 1'b1;
                  ld_val_s   = settle_ld(settle_r);
`else
                  state_nx_s  = FINISH;
                  status_nx_s = ST_TX_OK;
`endif
               end else begin
                  state_nx_s = TX_WAIT;
               end
            end
            RX_SETUP: begin
               if (tmr_zero_s) begin
                  state_nx_s = RX_START;
               end else begin
                  state_nx_s = RX_SETUP;
               end
            end
            RX_START: begin
               state_nx_s = RX_WAIT;
               ld_s       = 1'b1;
               if (tmo_r == {TMO_W{1'b0}}) begin
                  ld_val_s = TMR_ZERO;
               end else begin
                  ld_val_s = TMR_W'(tmo_r - TMO_W'(1'b1));
               end
            end
            RX_WAIT: begin
               if (crc_rise_s) begin
                  state_nx_s  = FINISH;
                  status_nx_s = ST_RX_OK;
               end else if ((tmo_r != {TMO_W{1'b0}}) && tmr_zero_s) begin
                  state_nx_s  = FINISH;
                  status_nx_s = ST_RX_TMO;
               end else begin
                  state_nx_s = RX_WAIT;
               end
            end
            FINISH: begin
               state_nx_s = IDLE;
            end
            default: begin
               state_nx_s = IDLE;
            end
         endcase
      end
   end

   assign rx_on_s = (state_nx_s == RX_SETUP) || (state_nx_s == RX_START) ||
                    (state_nx_s == RX_WAIT);

   // State, captured parameters and outputs registered from the next state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= IDLE;
         settle_r   <= {SETTLE_W{1'b0}};
         tmo_r      <= {TMO_W{1'b0}};
         crc_q_r    <= 1'b0;
         tx_en      <= 1'b0;
         rx_en      <= 1'b0;
         demod_en   <= 1'b0;
         txrx_rst   <= 1'b0;
         txstart    <= 1'b0;
         rxstart    <= 1'b0;
         lpf_pd     <= 1'b1;
         limiter_pd <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         status     <= ST_TX_OK;
      end else begin
         state_r <= state_nx_s;
         if (accept_s) begin
            settle_r <= settle_cycles;
            tmo_r    <= rx_timeout;
         end else begin
            settle_r <= settle_r;
            tmo_r    <= tmo_r;
         end
         // A crc_valid still high from an earlier packet must not count as an edge.
         crc_q_r    <= (state_nx_s == RX_START) ? 1'b0 : crc_valid;
         tx_en      <= (state_nx_s == TX_SETUP) || (state_nx_s == TX_START) ||
                       (state_nx_s == TX_WAIT);
         rx_en      <= rx_on_s;
         demod_en   <= rx_on_s;
         lpf_pd     <= ~rx_on_s;
         limiter_pd <= ~rx_on_s;
         txrx_rst   <= ((state_nx_s == TX_SETUP) && (state_r != TX_SETUP)) ||
                       ((state_nx_s == RX_SETUP) && (state_r != RX_SETUP));
         txstart    <= (state_nx_s == TX_START);
         rxstart    <= (state_nx_s == RX_START);
         busy       <= (state_nx_s != IDLE);
         done       <= (state_nx_s == FINISH);
         status     <= status_nx_s;
      end
   end

endmodule

// File: tb/tb_txrx_seq.sv
// Self-checking bench for txrx_seq: table of transactions with expected
// start/done cycles and status, checked by queue-based scoreboards.
module tb_txrx_seq;
   import txrx_seq_pkg::*;

   localparam int K_TX = 0, K_RX = 1, K_ABT_TX = 2, K_ABT_RX = 3, K_BOTH = 4, K_STALE = 5;

   typedef struct {
      int         kind;
      int         settle;
      int         tmo;
      int         dly;
      int         has_start;
      int         start_ofs;
      logic [1:0] exp_status;
      int         done_ofs;
   } vec_t;
   typedef struct { logic [1:0] status; int cyc; } done_exp_t;
   typedef struct { logic is_tx; int cyc; } start_exp_t;

   logic        clk = 1'b0, rst = 1'b0;
   logic        cmd_tx = 1'b0, cmd_rx = 1'b0, abort = 1'b0;
   logic [7:0]  settle_cycles = 8'd0;
   logic [15:0] rx_timeout = 16'd0;
   logic        txready = 1'b1, crc_valid = 1'b0;
   logic        tx_en, rx_en, demod_en, txrx_rst, txstart, rxstart;
   logic        lpf_pd, limiter_pd, busy, done;
   logic [1:0]  status;

   int total = 0, bad = 0, cyc = 0;
   done_exp_t  done_q[$];
   start_exp_t start_q[$];
   vec_t       vt[$];

   txrx_seq dut (
      .clk(clk), .rst(rst), .cmd_tx(cmd_tx), .cmd_rx(cmd_rx), .abort(abort),
      .settle_cycles(settle_cycles), .rx_timeout(rx_timeout), .txready(txready),
      .crc_valid(crc_valid), .tx_en(tx_en), .rx_en(rx_en), .demod_en(demod_en),
      .txrx_rst(txrx_rst), .txstart(txstart), .rxstart(rxstart), .lpf_pd(lpf_pd),
      .limiter_pd(limiter_pd), .busy(busy), .done(done), .status(status)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Scoreboards: done pulses and start pulses against the expected queues.
   always @(negedge clk) begin
      done_exp_t  de;
      start_exp_t se;
      if (done) begin
         if (done_q.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            de = done_q.pop_front();
            check("done_cycle", cyc, de.cyc);
            check("done_status", int'(status), int'(de.status));
            check("finish_outs", int'({tx_en, rx_en, demod_en, lpf_pd, limiter_pd, busy}),
                  int'(6'b000111));
         end
      end
      if (txstart && rxstart) begin
         check("both_starts", 1, 0);
      end else if (txstart || rxstart) begin
         if (start_q.size() == 0) begin
            check("unexpected_start", int'({txstart, rxstart}), 0);
         end else begin
            se = start_q.pop_front();
            check("start_kind_tx", int'(txstart), int'(se.is_tx));
            check("start_cycle", cyc, se.cyc);
         end
      end
   end

   task automatic check_reset_vals(input string name);
      check(name, int'({tx_en, rx_en, demod_en, txrx_rst, txstart, rxstart,
                        lpf_pd, limiter_pd, busy, done, status}), int'(12'b000000110000));
   endtask

   // Called at posedge+1 of the command cycle; returns once the DUT is idle again.
   task automatic run_vec(input vec_t v);
      int   c, s, t;
      logic is_rx, is_tx;
      bit   fin;
      c     = cyc;
      s     = c + v.start_ofs;
      is_rx = (v.kind == K_RX) || (v.kind == K_ABT_RX) || (v.kind == K_STALE);
      is_tx = ~is_rx;
      settle_cycles = 8'(v.settle);
      rx_timeout    = 16'(v.tmo);
      cmd_tx    = is_tx;
      cmd_rx    = is_rx || (v.kind == K_BOTH);
      crc_valid = (v.kind == K_STALE);
      txready   = 1'b1;
      done_q.push_back('{v.exp_status, s + v.done_ofs});
      if (v.has_start != 0) start_q.push_back('{is_tx, s});
      fin = 1'b0;
      while (!fin) begin
         @(posedge clk); #1;
         t = cyc;
         if (done_q.size() == 0 && start_q.size() == 0) begin
            check("idle_after", int'({busy, done}), 0);
            check("status_hold", int'(status), int'(v.exp_status));
            fin = 1'b1;
         end else if (t > c + 3000) begin
            check("txn_budget", t, c + 3000);
            done_q.delete();
            start_q.delete();
            fin = 1'b1;
         end else begin
            cmd_tx = 1'b0;
            cmd_rx = 1'b0;
            if (t == c + 1) begin
               settle_cycles = 8'd200;
               rx_timeout    = 16'd3;
            end
            case (v.kind)
               K_TX, K_BOTH: begin
                  txready = (t <= s) || (t >= s + v.dly);
                  cmd_rx  = (v.kind == K_TX) && (t == s + 2);
               end
               K_ABT_TX: begin
                  txready = 1'b0;
                  abort   = (t == s + v.dly);
               end
               K_RX:     crc_valid = (v.dly > 0) && (t == s + v.dly);
               K_STALE:  crc_valid = (t <= s + 1) || (t == s + v.dly);
               K_ABT_RX: abort = (t == s + v.dly);
               default:  abort = 1'b0;
            endcase
            @(negedge clk);
            if (t == c + 1)
               check("accept_outs", int'({busy, txrx_rst, tx_en, rx_en, demod_en, lpf_pd, limiter_pd}),
                     int'({1'b1, 1'b1, is_tx, is_rx, is_rx, ~is_rx, ~is_rx}));
            if (t == c + 2 && t < s + v.done_ofs) check("rst_single", int'(txrx_rst), 0);
            if (is_rx && v.has_start != 0 && t == s)
               check("rx_analog_on", int'({lpf_pd, limiter_pd, demod_en, rx_en}), int'(4'b0011));
         end
      end
      cmd_tx = 1'b0; cmd_rx = 1'b0; abort = 1'b0; txready = 1'b1; crc_valid = 1'b0;
   endtask

   initial begin
      int c;
      // kind, settle, tmo, dly, has_start, start_ofs, status, done_ofs (both offsets from start pulse)
`ifndef TXRX_SEQ_AUTO_RX_EN
      vt.push_back('{K_TX,     4,    0, 285, 1,   5, ST_TX_OK,  286});
      vt.push_back('{K_TX,     0,    0,   5, 1,   2, ST_TX_OK,  130});
      vt.push_back('{K_TX,     1,    0, 128, 1,   2, ST_TX_OK,  130});
      vt.push_back('{K_TX,     2,    0, 129, 1,   3, ST_TX_OK,  130});
      vt.push_back('{K_BOTH,   2,    0, 140, 1,   3, ST_TX_OK,  141});
`endif
      vt.push_back('{K_RX,     3, 1000, 400, 1,   4, ST_RX_OK,  401});
      vt.push_back('{K_RX,     2,   50,   0, 1,   3, ST_RX_TMO,  51});
      vt.push_back('{K_RX,     1,   20,  20, 1,   2, ST_RX_OK,   21});
      vt.push_back('{K_RX,     1,   20,  21, 1,   2, ST_RX_TMO,  21});
      vt.push_back('{K_RX,     5,    1,   0, 1,   6, ST_RX_TMO,   2});
      vt.push_back('{K_ABT_TX, 3,    0,  50, 1,   4, ST_ABORT,   51});
      vt.push_back('{K_ABT_RX, 6,    0,  -3, 0,   7, ST_ABORT,   -2});
      vt.push_back('{K_STALE,  2,    0,  10, 1,   3, ST_RX_OK,   11});
      vt.push_back('{K_ABT_RX, 1,    0,  30, 1,   2, ST_ABORT,   31});
      vt.push_back('{K_ABT_TX, 255,  0,   0, 1, 256, ST_ABORT,    1});

      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("reset_vals");
      @(negedge clk);
      rst = 1'b1;
      while (cyc != 10) begin
         @(posedge clk); #1;
      end
      foreach (vt[i]) run_vec(vt[i]);

      // Asynchronous reset in RX_WAIT: outputs drop at once and no done follows.
      c = cyc;
      settle_cycles = 8'd1; rx_timeout = 16'd0; cmd_rx = 1'b1;
      start_q.push_back('{1'b0, c + 2});
      @(posedge clk); #1;
      cmd_rx = 1'b0;
      repeat (8) @(posedge clk);
      #3 rst = 1'b0;
      #1 check_reset_vals("reset_async");
      repeat (3) @(negedge clk);
      check("reset_start_seen", start_q.size(), 0);
      rst = 1'b1;
      @(posedge clk); #1;
      run_vec('{K_RX, 2, 100, 30, 1, 3, ST_RX_OK, 31});

`ifdef TXRX_SEQ_AUTO_RX_EN
      // TX success turns straight into RX with a single done at the end.
      c = cyc;
      settle_cycles = 8'd2; rx_timeout = 16'd0; cmd_tx = 1'b1; txready = 1'b0;
      start_q.push_back('{1'b1, c + 3});
      start_q.push_back('{1'b0, c + 136});
      done_q.push_back('{ST_RX_OK, c + 147});
      for (int i = 0; i < 160; i++) begin
         @(posedge clk); #1;
         cmd_tx    = 1'b0;
         txready   = (cyc >= c + 133);
         crc_valid = (cyc == c + 146);
         @(negedge clk);
         if (cyc == c + 134)
            check("auto_turn", int'({tx_en, rx_en, txrx_rst, done}), int'(4'b0110));
      end
      crc_valid = 1'b0; txready = 1'b1;
`endif

      check("queues_drained", done_q.size() + start_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
